bp_flush_controller: RTL
========================

Name: bp_flush_controller

Overview:
- Sequences runtime invalidation of the branch predictor tag banks, e.g. on fence.i, an address-space change or debug entry.
- Owns the single shared tag-bank write port and arbitrates it between execution-stage predictor updates and a full-table clear sweep.
- Gates fetch-side prediction use while the sweep runs.
- Sits between the branch-results path and the per-way tag RAMs of the branch predictor.

Parameters:
- ENTRIES, 512, entries per way (power of two, >= 2).
- WAYS, 2, associativity (>= 1).
- ADDR_W, $clog2(ENTRIES), derived index width; not overridden.
- INIT_ON_RESET, 1, when 1 a sweep starts automatically on reset release.
- DROP_CNT_W, 8, width of the dropped-update counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush_req  in  1  single-cycle or level request for a full clear
- flush_done  out  1  one-cycle pulse when a sweep completes
- busy  out  1  sweep in progress
- upd_valid  in  1  predictor update from execution stage
- upd_addr  in  ADDR_W  update index (pc[2 +: ADDR_W])
- upd_way  in  WAYS  one-hot update way
- ram_we  out  WAYS  per-way tag write enable
- ram_waddr  out  ADDR_W  tag write index
- ram_clear  out  1  1 = write the entry with valid=0 (sweep); 0 = write the normal update entry
- lookup_disable  out  1  forces predictor use_prediction low
- dropped_updates  out  DROP_CNT_W  saturating count of updates discarded during sweeps

Behaviour:
- Reset is synchronous, active-high, on clk.
- Reset values: state IDLE, counter 0, pending 0, dropped_updates 0. busy, flush_done, ram_we, ram_clear and lookup_disable are all 0.
- If INIT_ON_RESET=1, the first cycle after rst deasserts is in SWEEP.
- States:
  - IDLE: flush_req=1 -> SWEEP next cycle, counter <= 0.
  - SWEEP: busy=1, lookup_disable=1, ram_we=all ones, ram_waddr=counter, ram_clear=1. Counter increments every cycle. At counter==ENTRIES-1 the write occurs and the state moves to DONE; the counter wraps to 0. A sweep is exactly ENTRIES cycles, with addresses 0..ENTRIES-1 in order and no stalls.
  - DONE: one cycle. flush_done=1, busy=0, lookup_disable=0. If pending=1 or flush_req=1 -> SWEEP, with pending cleared and counter 0. Otherwise -> IDLE.
- flush_req while in SWEEP sets pending. Multiple requests coalesce into one extra sweep. The request is never lost.
- Outside SWEEP, the write port passes updates through: ram_we = upd_way & {WAYS{upd_valid}}, ram_waddr=upd_addr, ram_clear=0. This is combinational, with zero-cycle latency.
- upd_valid in SWEEP: the update is discarded (no write), and dropped_updates increments, saturating at all ones.
- Simultaneous flush_req and upd_valid in IDLE or DONE: the update is written that cycle, and the sweep begins the next cycle.
- rst asserted mid-sweep: the sweep aborts immediately and takes reset values. If INIT_ON_RESET=1 it restarts from address 0 after release.
- flush_done never pulses for an aborted sweep.

Test Plan:
- ENTRIES=8, WAYS=2, INIT_ON_RESET=1. Release rst at cycle 0 -> cycles 1..8 have ram_we=2'b11, ram_clear=1 and ram_waddr 0..7; cycle 9 has flush_done=1 and busy=0.
- Idle with upd_valid=1, upd_addr=5, upd_way=2'b10 -> same cycle ram_we=2'b10, ram_waddr=5, ram_clear=0.
- Mid-sweep, at waddr=3, assert upd_valid for 3 cycles -> no update writes, dropped_updates=3, and the sweep sequence is unchanged.
- DROP_CNT_W=2 with 5 dropped updates -> dropped_updates saturates at 3.
- Pulse flush_req twice during a sweep -> exactly one flush_done, then one back-to-back second sweep of 8 cycles, then a second flush_done.
- Assert rst at waddr=4 -> all outputs 0 next cycle and no flush_done. After release the sweep restarts at waddr=0.

Source files
------------

// File: rtl/bp_flush_controller_if.sv
// Tag-bank write port and flush control bundle for the branch predictor flush controller.
// master = controller side, slave = predictor/exec side.
interface bp_flush_controller_if #(
    parameter int ENTRIES    = 512,
    parameter int WAYS       = 2,
    parameter int DROP_CNT_W = 8
);
    localparam int ADDR_W = $clog2(ENTRIES);

    // Handshake: upd_valid has no ready. An update is always accepted in the cycle it is
    // presented; during a sweep it is discarded and counted in dropped_updates instead.
    logic                  flush_req;
    logic                  flush_done;
    logic                  busy;
    logic                  upd_valid;
    logic [ADDR_W-1:0]     upd_addr;
    logic [WAYS-1:0]       upd_way;
    logic [WAYS-1:0]       ram_we;
    logic [ADDR_W-1:0]     ram_waddr;
    logic                  ram_clear;
    logic                  lookup_disable;
    logic [DROP_CNT_W-1:0] dropped_updates;
    logic [1:0]            dbg_state;

    modport master (
        input  flush_req, upd_valid, upd_addr, upd_way,
        output flush_done, busy, ram_we, ram_waddr, ram_clear, lookup_disable,
               dropped_updates, dbg_state
    );

    modport slave (
        output flush_req, upd_valid, upd_addr, upd_way,
        input  flush_done, busy, ram_we, ram_waddr, ram_clear, lookup_disable,
               dropped_updates, dbg_state
    );
endinterface

// File: rtl/bp_flush_controller.sv
// Branch predictor tag-bank flush controller: arbitrates the shared tag write port between
// execution updates and a full-table clear sweep, and gates prediction use while sweeping.
module bp_flush_controller #(
    parameter int ENTRIES       = 512,
    parameter int WAYS          = 2,
    parameter int INIT_ON_RESET = 1,
    parameter int DROP_CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    bp_flush_controller_if.master   bus
);
    localparam int ADDR_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state_q;
    logic [ADDR_W-1:0]     cnt_q;
    logic                  pending_q;
    logic                  init_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DROP_CNT_W-1:0] drop_q;
    logic                  sweep;

    // init_q requests the power-on sweep without occupying pending_q, which only records
    // requests that arrive while a sweep is already running.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            init_q    <= (INIT_ON_RESET != 0);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.flush_req || init_q) begin
                        state_q <= S_SWEEP;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        init_q  <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus.flush_req) begin
                        pending_q <= 1'b1;
                    end
                    if (bus.upd_valid && (drop_q != {DROP_CNT_W{1'b1}})) begin
                        drop_q <= drop_q + 1'b1;
                    end
                    if (cnt_q == ADDR_W'(ENTRIES - 1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (pending_q || bus.flush_req) begin
                        state_q   <= S_SWEEP;
                        pending_q <= 1'b0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sweep = (state_q == S_SWEEP);

    // Outside a sweep the update path reaches the RAMs in the same cycle.
    assign bus.ram_we          = sweep ? {WAYS{1'b1}} : (bus.upd_way & {WAYS{bus.upd_valid}});
    assign bus.ram_waddr       = sweep ? cnt_q : bus.upd_addr;
    assign bus.ram_clear       = sweep;
    assign bus.busy            = busy_q;
    assign bus.lookup_disable  = busy_q;
    assign bus.flush_done      = done_q;
    assign bus.dropped_updates = drop_q;
    assign bus.dbg_state       = state_q;
endmodule
